// File: rtl/yantar_pkg.sv
// yantar_pkg: shared constants, types and port-lookup helper for the read-port scheduler
package yantar_pkg;
    localparam int YANTAR_NINS = 5;
    localparam int YANTAR_NRD  = 7;
    localparam int YANTAR_AW   = 6;

    typedef logic [YANTAR_AW-1:0] reg_addr_t;
    typedef logic [2:0]           port_idx_t;

    // Returns {found, port}: a port already carrying addr wins, else the lowest free port
    function automatic logic [3:0] find_port(
        input logic [YANTAR_NRD-1:0]      occ,
        input reg_addr_t [YANTAR_NRD-1:0] addr,
        input reg_addr_t                  a
    );
        logic      hit;
        logic      ok;
        port_idx_t p;
        hit = 1'b0;
        ok  = 1'b0;
        p   = '0;
        for (int i = YANTAR_NRD - 1; i >= 0; i--) begin
            if (occ[i] && addr[i] == a) begin
                hit = 1'b1;
                p   = port_idx_t'(i);
            end
        end
        if (!hit) begin
            for (int i = YANTAR_NRD - 1; i >= 0; i--) begin
                if (!occ[i]) begin
                    ok = 1'b1;
                    p  = port_idx_t'(i);
                end
            end
        end
        return {hit || ok, p};
    endfunction
endpackage

// File: rtl/yantar_rdport_sched_if.sv
// yantar_rdport_sched_if: decode-group handshake and register-file read-port bundle
interface yantar_rdport_sched_if;
    import yantar_pkg::*;

    logic                                       stall;
    logic                                       grp_valid;
    logic [YANTAR_NINS-1:0]                     grp_ins_valid;
    reg_addr_t [YANTAR_NINS-1:0]                grp_rA;
    reg_addr_t [YANTAR_NINS-1:0]                grp_rB;
    logic [YANTAR_NINS-1:0]                     grp_rA_use;
    logic [YANTAR_NINS-1:0]                     grp_rB_use;
    logic                                       grp_ready;
    reg_addr_t [YANTAR_NRD-1:0]                 rd_addr;
    logic [YANTAR_NRD-1:0]                      rd_en;
    port_idx_t [YANTAR_NINS-1:0][1:0]           src_port;
    logic [YANTAR_NINS-1:0]                     iss_valid;
    logic                                       busy;

    modport master (
        output stall, grp_valid, grp_ins_valid, grp_rA, grp_rB, grp_rA_use, grp_rB_use,
        input  grp_ready, rd_addr, rd_en, src_port, iss_valid, busy
    );

    modport slave (
        input  stall, grp_valid, grp_ins_valid, grp_rA, grp_rB, grp_rA_use, grp_rB_use,
        output grp_ready, rd_addr, rd_en, src_port, iss_valid, busy
    );
endinterface

// File: rtl/yantar_rdport_alloc_slot.sv
// yantar_rdport_alloc_slot: one combinational step of the in-order read-port packing chain
module yantar_rdport_alloc_slot
    import yantar_pkg::*;
(
    input  logic [YANTAR_NRD-1:0]      i_occ,
    input  reg_addr_t [YANTAR_NRD-1:0] i_addr,
    input  logic                       i_blk,
    input  logic                       i_pend,
    input  reg_addr_t                  i_ra,
    input  reg_addr_t                  i_rb,
    input  logic                       i_ua,
    input  logic                       i_ub,
    output logic [YANTAR_NRD-1:0]      o_occ,
    output reg_addr_t [YANTAR_NRD-1:0] o_addr,
    output port_idx_t [1:0]            o_src,
    output logic                       o_iss,
    output logic                       o_blk
);
    logic [3:0]                 w_fa;
    logic [3:0]                 w_fb;
    logic [YANTAR_NRD-1:0]      w_occ_a;
    reg_addr_t [YANTAR_NRD-1:0] w_addr_a;
    logic                       w_fit;

    // Place A then B (B may share A's port); commit only if both fit and nothing earlier blocked
    always_comb begin
        w_fa = find_port(i_occ, i_addr, i_ra);
        w_occ_a = i_occ;
        w_addr_a = i_addr;
        if (i_ua) begin
            w_occ_a[w_fa[2:0]] = 1'b1;
            w_addr_a[w_fa[2:0]] = i_ra;
        end
        w_fb = find_port(w_occ_a, w_addr_a, i_rb);
        w_fit = (!i_ua || w_fa[3]) && (!i_ub || w_fb[3]);
        o_iss = i_pend && !i_blk && w_fit;
        o_blk = i_blk || (i_pend && !w_fit);
        o_occ = i_occ;
        o_addr = i_addr;
        o_src = '0;
        if (o_iss) begin
            o_occ = w_occ_a;
            o_addr = w_addr_a;
            if (i_ub) begin
                o_occ[w_fb[2:0]] = 1'b1;
                o_addr[w_fb[2:0]] = i_rb;
            end
            o_src[0] = i_ua ? w_fa[2:0] : '0;
            o_src[1] = i_ub ? w_fb[2:0] : '0;
        end
    end
endmodule

// File: rtl/yantar_rdport_sched.sv
// yantar_rdport_sched: packs a held decode group onto the register-file read ports, splitting across cycles
module yantar_rdport_sched
    import yantar_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    yantar_rdport_sched_if.slave bus
);
    localparam int NINS = YANTAR_NINS;
    localparam int NRD  = YANTAR_NRD;

    logic [NINS-1:0]     r_pend;
    logic [NINS-1:0]     r_ua;
    logic [NINS-1:0]     r_ub;
    reg_addr_t [NINS-1:0] r_ra;
    reg_addr_t [NINS-1:0] r_rb;

    logic [NRD-1:0]      w_occ1, w_occ2, w_occ3, w_occ4, w_occ5;
    reg_addr_t [NRD-1:0] w_addr1, w_addr2, w_addr3, w_addr4, w_addr5;
    logic                w_blk1, w_blk2, w_blk3, w_blk4, w_blk5;
    logic                w_take;

    assign w_take = bus.grp_valid && bus.grp_ready && !bus.stall;

    // A blocked slot is exactly the case where pending slots survive this round
    assign bus.grp_ready = !bus.stall && !w_blk5;
    assign bus.busy      = |r_pend;
    assign bus.rd_en     = w_occ5;
    assign bus.rd_addr   = w_addr5;

    yantar_rdport_alloc_slot u_slot0 (
        .i_occ('0), .i_addr('0), .i_blk(1'b0),
        .i_pend(r_pend[0]), .i_ra(r_ra[0]), .i_rb(r_rb[0]), .i_ua(r_ua[0]), .i_ub(r_ub[0]),
        .o_occ(w_occ1), .o_addr(w_addr1), .o_src(bus.src_port[0]), .o_iss(bus.iss_valid[0]), .o_blk(w_blk1)
    );
    yantar_rdport_alloc_slot u_slot1 (
        .i_occ(w_occ1), .i_addr(w_addr1), .i_blk(w_blk1),
        .i_pend(r_pend[1]), .i_ra(r_ra[1]), .i_rb(r_rb[1]), .i_ua(r_ua[1]), .i_ub(r_ub[1]),
        .o_occ(w_occ2), .o_addr(w_addr2), .o_src(bus.src_port[1]), .o_iss(bus.iss_valid[1]), .o_blk(w_blk2)
    );
    yantar_rdport_alloc_slot u_slot2 (
        .i_occ(w_occ2), .i_addr(w_addr2), .i_blk(w_blk2),
        .i_pend(r_pend[2]), .i_ra(r_ra[2]), .i_rb(r_rb[2]), .i_ua(r_ua[2]), .i_ub(r_ub[2]),
        .o_occ(w_occ3), .o_addr(w_addr3), .o_src(bus.src_port[2]), .o_iss(bus.iss_valid[2]), .o_blk(w_blk3)
    );
    yantar_rdport_alloc_slot u_slot3 (
        .i_occ(w_occ3), .i_addr(w_addr3), .i_blk(w_blk3),
        .i_pend(r_pend[3]), .i_ra(r_ra[3]), .i_rb(r_rb[3]), .i_ua(r_ua[3]), .i_ub(r_ub[3]),
        .o_occ(w_occ4), .o_addr(w_addr4), .o_src(bus.src_port[3]), .o_iss(bus.iss_valid[3]), .o_blk(w_blk4)
    );
    yantar_rdport_alloc_slot u_slot4 (
        .i_occ(w_occ4), .i_addr(w_addr4), .i_blk(w_blk4),
        .i_pend(r_pend[4]), .i_ra(r_ra[4]), .i_rb(r_rb[4]), .i_ua(r_ua[4]), .i_ub(r_ub[4]),
        .o_occ(w_occ5), .o_addr(w_addr5), .o_src(bus.src_port[4]), .o_iss(bus.iss_valid[4]), .o_blk(w_blk5)
    );

    // Capture a new group when ready, otherwise retire issued slots unless stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
            r_ua <= '0;
            r_ub <= '0;
            r_ra <= '0;
            r_rb <= '0;
        end else if (w_take) begin
            r_pend <= bus.grp_ins_valid;
            r_ua <= bus.grp_rA_use;
            r_ub <= bus.grp_rB_use;
            r_ra <= bus.grp_rA;
            r_rb <= bus.grp_rB;
        end else if (!bus.stall) begin
            r_pend <= r_pend & ~bus.iss_valid;
        end
    end
endmodule
